// File: rtl/subtractor_borrow_seq.sv
// Multi-cycle unsigned subtractor: diff = a - b, W bits per clock from the LSB slice up,
// with the borrow chained between slices and a start/ready/done handshake.
module subtractor_borrow_seq #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int NS = N / W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           borrow_q, borrow_d;
  logic           bout_q, bout_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;

  logic [W-1:0]   a_slc;
  logic [W-1:0]   b_slc;
  logic [W:0]     slc_res;

  always_comb begin
    a_slc = '0;
    b_slc = '0;
    for (int i = 0; i < NS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_slc = a_q[i*W +: W];
        b_slc = b_q[i*W +: W];
      end
    end
    // W+1 bit difference: the top bit is the borrow into the next slice
    slc_res = {1'b0, a_slc} - {1'b0, b_slc} - {{W{1'b0}}, borrow_q};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SUB;
        end
      end
      S_SUB: begin
        for (int i = 0; i < NS; i++) begin
          if (cnt_q == CW'(i)) begin
            diff_d[i*W +: W] = slc_res[W-1:0];
          end
        end
        borrow_d = slc_res[W];
        if (cnt_q == CW'(NS - 1)) begin
          bout_d  = slc_res[W];
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // handshake outputs are registered copies of the next state
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_subtractor_borrow_seq.sv
// Bench for subtractor_borrow_seq: directed and random operations on three configurations,
// checked against plain a-b arithmetic and the handshake timing.
module tb_subtractor_borrow_seq;

  localparam int NS = 4;  // 16/4 slices

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit fin_b   = 1'b0;
  bit fin_c   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- N=16, W=4 (directed + random) ----
  logic        rst_n, start, ready, done, bout;
  logic [15:0] a, b, diff;

  subtractor_borrow_seq #(.N(16), .W(4)) dut (
    .clk(clk), .reset_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .diff(diff), .bout(bout)
  );

  // ---- N=8, W=8 ----
  logic       rst_b_n, start_b, ready_b, done_b, bout_b;
  logic [7:0] a_b, b_b, diff_b;

  subtractor_borrow_seq #(.N(8), .W(8)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .start(start_b), .a(a_b), .b(b_b),
    .ready(ready_b), .done(done_b), .diff(diff_b), .bout(bout_b)
  );

  // ---- N=12, W=1 ----
  logic        rst_c_n, start_c, ready_c, done_c, bout_c;
  logic [11:0] a_c, b_c, diff_c;

  subtractor_borrow_seq #(.N(12), .W(1)) dut_c (
    .clk(clk), .reset_n(rst_c_n), .start(start_c), .a(a_c), .b(b_c),
    .ready(ready_c), .done(done_c), .diff(diff_c), .bout(bout_c)
  );

  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input bit garble,
                        input string tag);
    int cyc;
    int guard;
    int pulses;
    logic [15:0] exp_d;
    logic        exp_bo;
    exp_d  = va - vb;
    exp_bo = (va < vb);
    guard  = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_ready_in"}, 32'(ready), 32'd1);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (garble) begin
      a = 16'($urandom); b = 16'($urandom);
    end else begin
      start = 1'b0;
    end
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (garble) begin
        a = 16'($urandom); b = 16'($urandom);
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(NS + 1));
    chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
    chk({tag, "_bout"}, 32'(bout), 32'(exp_bo));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready), 32'd1);
    chk({tag, "_diff_hold"}, 32'(diff), 32'(exp_d));
    if (garble) begin
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        pulses += int'(done);
      end
      chk({tag, "_extra_done"}, 32'(pulses), 32'd0);
    end
  endtask

  initial begin : main_seq
    int pulses;
    int cyc;
    int last_acc;
    int nacc;
    int npop;
    int g;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ea, eb, ra, rb;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0234, 1'b0, "t1");
    run_op(16'h0000, 16'h0001, 1'b0, "t2a");
    run_op(16'h1000, 16'h0001, 1'b0, "t2b");
    run_op(16'hABCD, 16'hABCD, 1'b0, "t3a");
    run_op(16'h0001, 16'hFFFF, 1'b0, "t3b");
    run_op(16'h9F3C, 16'h1234, 1'b1, "t4");
    run_op(16'h0001, 16'hFFFF, 1'b0, "t5pre");

    // reset during the second SUB cycle
    a = 16'h5555; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_diff", 32'(diff), 32'd0);
    chk("t5_bout", 32'(bout), 32'd0);
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      pulses += int'(done);
    end
    chk("t5_no_done", 32'(pulses), 32'd0);
    run_op(16'h5555, 16'h1111, 1'b0, "t5post");

    // back-to-back with start held high
    nacc = 0; npop = 0; last_acc = 0; cyc = 0;
    while (npop < 20 && cyc < 400) begin
      if (done) begin
        if (qa.size() > 0) begin
          ea = qa.pop_front(); eb = qb.pop_front();
          chk("t6_diff", 32'(diff), 32'(16'(ea - eb)));
          chk("t6_bout", 32'(bout), 32'(ea < eb));
        end else begin
          chk("t6_spurious_done", 32'd1, 32'd0);
        end
        npop++;
      end
      if (ready) begin
        if (nacc > 0 && nacc < 21) chk("t6_interval", 32'(cyc - last_acc), 32'(NS + 2));
        last_acc = cyc;
        if (nacc < 20) begin
          ra = 16'($urandom); rb = 16'($urandom);
          a = ra; b = rb; start = 1'b1;
          qa.push_back(ra); qb.push_back(rb);
        end else begin
          start = 1'b0;
        end
        nacc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("t6_count", 32'(npop), 32'd20);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0:       begin ra = 16'h0000; rb = 16'($urandom); end
        1:       begin ra = 16'($urandom); rb = 16'hFFFF; end
        2:       begin ra = 16'($urandom); rb = ra; end
        default: begin ra = 16'($urandom); rb = 16'($urandom); end
      endcase
      run_op(ra, rb, ($urandom_range(0, 9) == 0), "rnd16");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    g = 0;
    while (!(fin_b && fin_c) && g < 60000) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("other_cfg_finished", 32'(fin_b && fin_c), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : cfg_b
    int cyc;
    logic [7:0] va, vb;
    rst_b_n = 1'b0; start_b = 1'b0; a_b = '0; b_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("b_rst_ready", 32'(ready_b), 32'd1);
    rst_b_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      va = 8'($urandom); vb = 8'($urandom);
      a_b = va; b_b = vb; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      cyc = 1;
      while (!done_b && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("b_latency", 32'(cyc), 32'd2);
      chk("b_diff", 32'(diff_b), 32'(8'(va - vb)));
      chk("b_bout", 32'(bout_b), 32'(va < vb));
      @(posedge clk); #1;
      chk("b_ready", 32'(ready_b), 32'd1);
    end
    fin_b = 1'b1;
  end

  initial begin : cfg_c
    int cyc;
    logic [11:0] va, vb;
    rst_c_n = 1'b0; start_c = 1'b0; a_c = '0; b_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("c_rst_ready", 32'(ready_c), 32'd1);
    rst_c_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      va = 12'($urandom); vb = 12'($urandom);
      a_c = va; b_c = vb; start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      a_c = 12'($urandom); b_c = 12'($urandom);
      cyc = 1;
      while (!done_c && cyc < 60) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("c_latency", 32'(cyc), 32'd13);
      chk("c_diff", 32'(diff_c), 32'(12'(va - vb)));
      chk("c_bout", 32'(bout_c), 32'(va < vb));
      @(posedge clk); #1;
      chk("c_ready", 32'(ready_c), 32'd1);
    end
    fin_c = 1'b1;
  end

endmodule
